// File: rtl/lcd_nibble_receiver.sv
// Responder for the 4-bit HD44780-style LCD bus: rebuilds bytes from nibbles and tracks the DDRAM cursor.
// Optional timing checker is compiled in with `define LCD_RX_TIMING_CHECK_EN.
module lcd_nibble_receiver #(
  parameter int unsigned MIN_NIBBLE_GAP = 50,
  parameter int unsigned MIN_CMD_GAP    = 2000
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       iLCD_Enabled,
  input  logic       iLCD_RegisterSelect,
  input  logic       iLCD_ReadWrite,
  input  logic       iLCD_StrataFlashControl,
  input  logic [3:0] iLCD_Data,
  output logic       oByteValid,
  output logic [7:0] oByte,
  output logic       oByteIsData,
  output logic       oCharWrite,
  output logic [6:0] oCharAddr,
  output logic [6:0] oCursor,
  output logic       oFourBitMode,
  output logic       oProtocolError,
  output logic       oTimingError
);

  typedef enum logic [1:0] {ST_INIT8, ST_HI, ST_LO} state_t;

  state_t     state_q, state_d;
  logic [7:0] sync1_q, sync2_q;
  logic       e_prev_q;
  logic       seen3_q, seen3_d;
  logic [3:0] hi_q, hi_d;
  logic       hi_rs_q, hi_rs_d;
  logic       four_q, four_d;
  logic       perr_q, perr_d;
  logic       valid_q, valid_d;
  logic       cw_q, cw_d;
  logic [7:0] byte_q, byte_d;
  logic       isdata_q, isdata_d;
  logic [6:0] addr_q, addr_d;
  logic [6:0] cursor_q, cursor_d;

  logic       fall, s_rs, s_rw, s_sf;
  logic [3:0] s_nib;

  assign fall  = e_prev_q & ~sync2_q[7];
  assign s_rs  = sync2_q[6];
  assign s_rw  = sync2_q[5];
  assign s_sf  = sync2_q[4];
  assign s_nib = sync2_q[3:0];

  function automatic logic [6:0] next_addr(input logic [6:0] a);
    if (a == 7'h27)      return 7'h40;
    else if (a == 7'h67) return 7'h00;
    else                 return a + 7'd1;
  endfunction

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      e_prev_q <= 1'b0;
      state_q  <= ST_INIT8;
      seen3_q  <= 1'b0;
      hi_q     <= '0;
      hi_rs_q  <= 1'b0;
      four_q   <= 1'b0;
      perr_q   <= 1'b0;
      valid_q  <= 1'b0;
      cw_q     <= 1'b0;
      byte_q   <= '0;
      isdata_q <= 1'b0;
      addr_q   <= '0;
      cursor_q <= '0;
    end else begin
      sync1_q  <= {iLCD_Enabled, iLCD_RegisterSelect, iLCD_ReadWrite,
                   iLCD_StrataFlashControl, iLCD_Data};
      sync2_q  <= sync1_q;
      e_prev_q <= sync2_q[7];
      state_q  <= state_d;
      seen3_q  <= seen3_d;
      hi_q     <= hi_d;
      hi_rs_q  <= hi_rs_d;
      four_q   <= four_d;
      perr_q   <= perr_d;
      valid_q  <= valid_d;
      cw_q     <= cw_d;
      byte_q   <= byte_d;
      isdata_q <= isdata_d;
      addr_q   <= addr_d;
      cursor_q <= cursor_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    seen3_d  = seen3_q;
    hi_d     = hi_q;
    hi_rs_d  = hi_rs_q;
    four_d   = four_q;
    perr_d   = perr_q;
    valid_d  = 1'b0;
    cw_d     = 1'b0;
    byte_d   = byte_q;
    isdata_d = isdata_q;
    addr_d   = addr_q;
    cursor_d = cursor_q;

    // Cursor effect of the byte pulsed last cycle lands one cycle after the pulse.
    if (valid_q) begin
      if (isdata_q) begin
        cursor_d = next_addr(cursor_q);
      end else if (byte_q[7]) begin
        cursor_d = byte_q[6:0];
        if (byte_q[5:0] >= 6'h28) perr_d = 1'b1;
      end else if (byte_q == 8'h01 || byte_q == 8'h02 || byte_q == 8'h03) begin
        cursor_d = '0;
      end
    end

    if (fall) begin
      if (!s_sf) perr_d = 1'b1;
      if (s_rw) begin
        perr_d = 1'b1;
      end else begin
        case (state_q)
          ST_INIT8: begin
            if (s_nib == 4'h3) begin
              seen3_d = 1'b1;
            end else if (s_nib == 4'h2 && seen3_q) begin
              state_d = ST_HI;
              four_d  = 1'b1;
            end else begin
              perr_d = 1'b1;
            end
          end
          ST_HI: begin
            hi_d    = s_nib;
            hi_rs_d = s_rs;
            state_d = ST_LO;
          end
          ST_LO: begin
            state_d = ST_HI;
            if (s_rs != hi_rs_q) begin
              perr_d = 1'b1;
            end else begin
              valid_d  = 1'b1;
              byte_d   = {hi_q, s_nib};
              isdata_d = s_rs;
              if (s_rs) begin
                cw_d   = 1'b1;
                addr_d = cursor_q;
              end
            end
          end
          default: state_d = ST_INIT8;
        endcase
      end
    end
  end

  assign oByteValid     = valid_q;
  assign oByte          = byte_q;
  assign oByteIsData    = isdata_q;
  assign oCharWrite     = cw_q;
  assign oCharAddr      = addr_q;
  assign oCursor        = cursor_q;
  assign oFourBitMode   = four_q;
  assign oProtocolError = perr_q;

`ifdef LCD_RX_TIMING_CHECK_EN
  localparam int unsigned GW = (MIN_CMD_GAP < 2) ? 1 : $clog2(MIN_CMD_GAP + 1);

  logic [GW-1:0] gap_q, gap_d;
  logic          first_q, first_d;
  logic          terr_q, terr_d;

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      gap_q   <= '0;
      first_q <= 1'b1;
      terr_q  <= 1'b0;
    end else begin
      gap_q   <= gap_d;
      first_q <= first_d;
      terr_q  <= terr_d;
    end
  end

  // Counter holds clocks elapsed since the previous falling edge, saturating at the command gap.
  always_comb begin
    gap_d   = gap_q;
    first_d = first_q;
    terr_d  = terr_q;
    if (fall) begin
      gap_d   = GW'(1);
      first_d = 1'b0;
      if (!first_q) begin
        if (state_q == ST_LO) begin
          if (gap_q < GW'(MIN_NIBBLE_GAP)) terr_d = 1'b1;
        end else begin
          if (gap_q < GW'(MIN_CMD_GAP)) terr_d = 1'b1;
        end
      end
    end else if (gap_q < GW'(MIN_CMD_GAP)) begin
      gap_d = gap_q + GW'(1);
    end
  end

  assign oTimingError = terr_q;
`else
  assign oTimingError = 1'b0;
`endif

endmodule

// File: tb/tb_lcd_nibble_receiver.sv
// Self-checking bench for lcd_nibble_receiver: directed and random LCD bus traffic against a byte-level model.
module tb_lcd_nibble_receiver;

  localparam int unsigned NIB_GAP = 16;
  localparam int unsigned CMD_GAP = 40;

  logic       Clock = 1'b0;
  logic       Reset = 1'b0;
  logic       iE = 1'b0, iRS = 1'b0, iRW = 1'b0, iSF = 1'b1;
  logic [3:0] iD = '0;
  logic       oByteValid, oByteIsData, oCharWrite, oFourBitMode, oProtocolError, oTimingError;
  logic [7:0] oByte;
  logic [6:0] oCharAddr, oCursor;

  lcd_nibble_receiver #(.MIN_NIBBLE_GAP(NIB_GAP), .MIN_CMD_GAP(CMD_GAP)) dut (
    .Clock(Clock), .Reset(Reset),
    .iLCD_Enabled(iE), .iLCD_RegisterSelect(iRS), .iLCD_ReadWrite(iRW),
    .iLCD_StrataFlashControl(iSF), .iLCD_Data(iD),
    .oByteValid(oByteValid), .oByte(oByte), .oByteIsData(oByteIsData),
    .oCharWrite(oCharWrite), .oCharAddr(oCharAddr), .oCursor(oCursor),
    .oFourBitMode(oFourBitMode), .oProtocolError(oProtocolError),
    .oTimingError(oTimingError)
  );

  always #5 Clock = ~Clock;

  int n_vec = 0, n_err = 0;
  int seen_valid = 0, seen_cw = 0, exp_valid = 0, exp_cw = 0;

  always @(negedge Clock) begin
    if (oByteValid === 1'b1) seen_valid++;
    if (oCharWrite === 1'b1) seen_cw++;
  end

  // Reference model: bus-level view of the display controller.
  bit         m_four, m_seen3, m_have_hi, m_hirs, m_perr, m_terr, m_first;
  logic [3:0] m_hi;
  logic [6:0] m_cur;
  int         m_interval;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge Clock);
    Reset = 1'b0; iE = 1'b0;
    repeat (3) @(negedge Clock);
    Reset = 1'b1;
    m_four = 0; m_seen3 = 0; m_have_hi = 0; m_hirs = 0; m_perr = 0; m_terr = 0;
    m_first = 1; m_hi = '0; m_cur = '0; m_interval = 0;
    @(posedge Clock); #1;
    chk("rst_valid", 32'(oByteValid), 0);
    chk("rst_byte", 32'(oByte), 0);
    chk("rst_isdata", 32'(oByteIsData), 0);
    chk("rst_cw", 32'(oCharWrite), 0);
    chk("rst_addr", 32'(oCharAddr), 0);
    chk("rst_cursor", 32'(oCursor), 0);
    chk("rst_four", 32'(oFourBitMode), 0);
    chk("rst_perr", 32'(oProtocolError), 0);
    chk("rst_terr", 32'(oTimingError), 0);
  endtask

  task automatic send_nibble(input logic rs, input logic rw, input logic sf,
                             input logic [3:0] nib, input int post);
    bit         ev, ecw;
    logic [7:0] eb;
    logic [6:0] ea;
    logic [6:0] a;
    @(negedge Clock);
    iRS = rs; iRW = rw; iSF = sf; iD = nib; iE = 1'b1;
    repeat (3) @(negedge Clock);
    iE = 1'b0;

    ev = 0; ecw = 0; eb = '0; ea = '0;
`ifdef LCD_RX_TIMING_CHECK_EN
    if (!m_first) begin
      if (m_four && m_have_hi) begin
        if (m_interval < int'(NIB_GAP)) m_terr = 1;
      end else if (m_interval < int'(CMD_GAP)) m_terr = 1;
    end
`endif
    if (!sf) m_perr = 1;
    if (rw) begin
      m_perr = 1;
    end else if (!m_four) begin
      if (nib == 4'h3) m_seen3 = 1;
      else if (nib == 4'h2 && m_seen3) m_four = 1;
      else m_perr = 1;
    end else if (!m_have_hi) begin
      m_hi = nib; m_hirs = rs; m_have_hi = 1;
    end else begin
      m_have_hi = 0;
      if (rs != m_hirs) begin
        m_perr = 1;
      end else begin
        ev = 1; eb = {m_hi, nib};
        exp_valid++;
        if (rs) begin
          ecw = 1; ea = m_cur; exp_cw++;
          if (m_cur == 7'h27) m_cur = 7'h40;
          else if (m_cur == 7'h67) m_cur = 7'h00;
          else m_cur = 7'((int'(m_cur) + 1) % 128);
        end else if (eb[7]) begin
          a = eb[6:0];
          m_cur = a;
          if ((a >= 7'h28 && a <= 7'h3F) || a >= 7'h68) m_perr = 1;
        end else if (eb >= 8'h01 && eb <= 8'h03) begin
          m_cur = '0;
        end
      end
    end

    for (int k = 1; k <= 3; k++) begin
      @(posedge Clock); #1;
      if (k < 3) chk("early_valid", 32'(oByteValid), 0);
    end
    chk("valid", 32'(oByteValid), 32'(ev));
    chk("charwrite", 32'(oCharWrite), 32'(ecw));
    if (ev) begin
      chk("byte", 32'(oByte), 32'(eb));
      chk("isdata", 32'(oByteIsData), 32'(rs));
    end
    if (ecw) chk("charaddr", 32'(oCharAddr), 32'(ea));
    @(posedge Clock); #1;
    chk("cursor", 32'(oCursor), 32'(m_cur));
    chk("perr", 32'(oProtocolError), 32'(m_perr));
    chk("fourbit", 32'(oFourBitMode), 32'(m_four));
    chk("terr", 32'(oTimingError), 32'(m_terr));
    repeat (post) @(negedge Clock);
    m_interval = 7 + post;
    m_first = 0;
  endtask

  task automatic send_byte(input logic rs, input logic [7:0] b);
    send_nibble(rs, 1'b0, 1'b1, b[7:4], 41);
    send_nibble(rs, 1'b0, 1'b1, b[3:0], 41);
  endtask

  task automatic do_init();
    send_nibble(1'b0, 1'b0, 1'b1, 4'h3, 41);
    send_nibble(1'b0, 1'b0, 1'b1, 4'h3, 41);
    send_nibble(1'b0, 1'b0, 1'b1, 4'h3, 41);
    send_nibble(1'b0, 1'b0, 1'b1, 4'h2, 41);
  endtask

  initial begin
    logic [7:0] b;
    int kind;

    do_reset();
    do_init();
    chk("init_four", 32'(oFourBitMode), 1);

    send_byte(1'b1, 8'h41);

    send_byte(1'b0, 8'hA7);
    send_byte(1'b1, 8'h58);
    send_byte(1'b1, 8'h59);
    send_byte(1'b0, 8'hE7);
    send_byte(1'b1, 8'h5A);

    send_byte(1'b0, 8'h95);
    send_byte(1'b0, 8'h01);
    chk("clear_cursor", 32'(oCursor), 0);

    for (int i = 0; i < 24; i++) begin
      kind = int'($urandom_range(0, 3));
      if (kind <= 1) begin
        b = 8'($urandom_range(8'h20, 8'h7E));
        send_byte(1'b1, b);
      end else if (kind == 2) begin
        b = 8'h80 | 8'($urandom_range(0, 127));
        send_byte(1'b0, b);
      end else begin
        b = 8'($urandom_range(0, 255));
        send_byte(1'b0, b);
      end
    end

    do_reset();
    do_init();
    send_nibble(1'b0, 1'b0, 1'b1, 4'h4, 41);
    send_nibble(1'b1, 1'b0, 1'b1, 4'h1, 41);
    send_nibble(1'b0, 1'b1, 1'b1, 4'h5, 41);
    send_byte(1'b1, 8'h42);
    chk("perr_sticky", 32'(oProtocolError), 1);

    do_reset();
    do_init();
    send_nibble(1'b1, 1'b0, 1'b0, 4'h4, 41);
    send_nibble(1'b1, 1'b0, 1'b1, 4'h3, 41);

    do_reset();
    do_init();
    send_nibble(1'b1, 1'b0, 1'b1, 4'h4, 41);
    do_reset();
    send_nibble(1'b1, 1'b0, 1'b1, 4'h4, 41);
    do_init();
    send_byte(1'b1, 8'h44);

    do_reset();
    do_init();
    send_nibble(1'b1, 1'b0, 1'b1, 4'h4, 3);
    send_nibble(1'b1, 1'b0, 1'b1, 4'h5, 41);
`ifdef LCD_RX_TIMING_CHECK_EN
    chk("terr_short_gap", 32'(oTimingError), 1);
`else
    chk("terr_short_gap", 32'(oTimingError), 0);
`endif

    repeat (5) @(negedge Clock);
    chk("valid_pulse_count", 32'(seen_valid), 32'(exp_valid));
    chk("cw_pulse_count", 32'(seen_cw), 32'(exp_cw));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "bench timeout");
  end

endmodule
